run_batcher: RTL and testbench
==============================

# run_batcher

Downstream consumer of the run engine's single-cycle `done` pulses. It groups completed runs into batches of BATCH and presents each batch count to the next stage over a valid/ready handshake. Runs that complete while a batch is waiting are buffered. An optional gap watchdog flushes a partial batch when the engine goes quiet.

## Interface
Parameters:
- BATCH, default 4: runs per full batch; legal range 1..15.
- TMO, default 16: idle cycles after the last `done_i` before a partial batch is flushed; legal minimum 2; only used with the timeout feature.
- CNT_W (localparam) = $clog2(BATCH+1): width of all run counts.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- done_i  in  1  one-cycle pulse per completed run, from the run engine's registered `done`.
- out_valid  out  1  batch available; registered.
- out_ready  in  1  downstream accepts the batch.
- out_count  out  CNT_W  runs in the presented batch; valid only while `out_valid`=1.
- out_timeout  out  1  presented batch was flushed by the watchdog; qualified by `out_valid`.
- overrun  out  1  one-cycle pulse: a `done_i` was lost because the pending buffer was saturated.
- busy  out  1  high in COLLECT or HOLD.

## Operation
- Reset values: state=IDLE; count, pend, gap, out_count = 0; out_valid, out_timeout, overrun, busy = 0.
- All outputs are registered and driven from a sequential output block.
- The FSM has three states: IDLE=0, COLLECT=1, HOLD=2. Any other encoding goes to IDLE.
- IDLE
  - On `done_i`, count becomes 1.
  - Next state is HOLD if BATCH==1, otherwise COLLECT.
- COLLECT
  - Each `done_i` increments count and clears gap.
  - When count reaches BATCH, go to HOLD with out_count=BATCH and out_timeout=0.
- HOLD
  - out_valid=1. out_count and out_timeout stay stable until the handshake.
  - A `done_i` increments pend, which saturates at BATCH.
  - A `done_i` arriving when pend==BATCH is dropped and pulses `overrun` the next cycle.
- Handshake (out_valid & out_ready): n = min(pend + done_i, BATCH); pend is cleared.
  - n==0: go to IDLE.
  - n==BATCH: stay in HOLD; out_count=BATCH, out_timeout=0, out_valid stays 1.
  - Otherwise: go to COLLECT with count=n and gap=0.
- Arithmetic:
  - All counts are unsigned CNT_W bits.
  - Additions saturate at BATCH and never wrap.
  - gap is $clog2(TMO) bits and saturates.
- Reset mid-batch discards count, pend and any presented batch without a handshake.

## Timing
- BATCH-th `done_i` sampled at edge N: out_valid=1 from cycle N+1.
- Handshake at edge M: out_valid=0 in cycle M+1, unless the next batch was already full, in which case it stays 1 with the new count.
- Back-to-back full batches can be accepted one per cycle.
- out_valid never falls without a handshake, except on reset.
- A `done_i` in the same cycle as the handshake is counted into the next batch and never lost.
- `overrun` rises the cycle after the dropped pulse and lasts exactly one cycle.

## Configuration
- Macro: RUN_BATCHER_TIMEOUT_EN.
- Defined:
  - In COLLECT, gap increments on every cycle without `done_i`.
  - When gap==TMO-1 and `done_i`=0, go to HOLD with out_count=count and out_timeout=1.
  - Result: the partial batch is presented TMO cycles after its last run.
- Undefined:
  - No gap counter; out_timeout is tied to 0.
  - COLLECT waits indefinitely for BATCH runs.

## Structure
- Package run_batcher_pkg holds:
  - the state encoding constants (IDLE, COLLECT, HOLD, 2 bits);
  - the default BATCH and TMO values;
  - the saturating-add function used for count and pend.
- Sub-module run_batcher_gap_timer holds the gap counter. It takes a clear input and an enable input and outputs an expiry flag. It is instantiated only under RUN_BATCHER_TIMEOUT_EN.

## Test plan
- BATCH=4, out_ready=1, four `done_i` pulses 11 cycles apart: out_valid=1 one cycle after the 4th pulse; out_count=4, out_timeout=0; out_valid low the following cycle.
- out_ready=0 for 20 cycles after a full batch, 6 `done_i` pulses during HOLD: pend saturates at 4 and `overrun` pulses twice. On ready, a second batch with out_count=4 is presented the next cycle.
- `done_i` coincident with the handshake, pend=2: COLLECT resumes with count=3, and one more pulse completes the batch.
- With the macro defined and TMO=16: two pulses, then silence. out_valid rises 16 cycles after the 2nd pulse with out_count=2 and out_timeout=1. Without the macro, out_valid stays 0.
- rst_n asserted while out_valid=1, count=4, pend=3: all outputs are 0 immediately; after release, the first `done_i` restarts at count=1.
- BATCH=1: each `done_i` yields out_valid the next cycle with out_count=1; with out_ready held high, consecutive pulses give consecutive batches.

Source files
------------

// File: rtl/run_batcher_pkg.sv
// rtl/run_batcher_pkg.sv - state encoding, defaults and saturating arithmetic for run_batcher
package run_batcher_pkg;

    // FSM encoding; any other value is treated as illegal and returns to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int unsigned BATCH_DEFAULT = 4;
    localparam int unsigned TMO_DEFAULT   = 16;

    // Unsigned add clamped to limit; run counts never wrap.
    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned limit);
        int unsigned sum;
        sum = a + b;
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/run_batcher_gap_timer.sv
// rtl/run_batcher_gap_timer.sv - saturating idle-cycle counter for the partial-batch watchdog
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the gap count (has priority over enable)
//   enable     : count one idle cycle
//   expired    : gap has reached TMO-1
module run_batcher_gap_timer #(
    parameter int unsigned TMO = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned GAP_W = $clog2(TMO);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TMO - 1);

    logic [GAP_W-1:0] gap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap <= '0;
        end else if (clear) begin
            gap <= '0;
        end else if (enable && (gap != GAP_MAX)) begin
            gap <= gap + 1'b1;
        end
    end

    assign expired = (gap == GAP_MAX);

endmodule

// File: rtl/run_batcher.sv
// rtl/run_batcher.sv - groups run-engine done pulses into batches presented over valid/ready
// Optional feature macro: RUN_BATCHER_TIMEOUT_EN (gap watchdog flushes partial batches).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   done_i       : one-cycle pulse per completed run
//   out_valid    : batch presented (registered)
//   out_ready    : downstream accepts the batch
//   out_count    : runs in the presented batch, valid with out_valid
//   out_timeout  : presented batch was flushed by the watchdog
//   overrun      : one-cycle pulse, a done_i was dropped with the pending buffer full
//   busy         : collecting or holding a batch
module run_batcher
    import run_batcher_pkg::*;
#(
    parameter  int unsigned BATCH = BATCH_DEFAULT,
    parameter  int unsigned TMO   = TMO_DEFAULT,
    localparam int unsigned CNT_W = $clog2(BATCH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_timeout,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BATCH);

    if ((BATCH < 1) || (BATCH > 15) || (TMO < 2)) begin : g_bad_params
        $error("run_batcher: BATCH must be 1..15 and TMO at least 2");
    end

    state_t           state, state_d;
    logic [CNT_W-1:0] count, count_d;
    logic [CNT_W-1:0] pend, pend_d;
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] out_count_d;
    logic             out_valid_d, out_timeout_d, overrun_d, busy_d;

`ifdef RUN_BATCHER_TIMEOUT_EN
    logic gap_expired;

    // Gap restarts whenever we are not collecting or a run arrives.
    run_batcher_gap_timer #(
        .TMO (TMO)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   ((state != COLLECT) || done_i),
        .enable  (state == COLLECT),
        .expired (gap_expired)
    );
`endif

    always_comb begin
        state_d       = state;
        count_d       = count;
        pend_d        = pend;
        out_valid_d   = out_valid;
        out_count_d   = out_count;
        out_timeout_d = out_timeout;
        overrun_d     = 1'b0;
        // Size of the next batch if a handshake happens this cycle; a done_i
        // coincident with the handshake is folded in here so it is not lost.
        n             = CNT_W'(sat_add(32'(pend), 32'(done_i), BATCH));

        case (state)
            IDLE: begin
                if (done_i) begin
                    count_d = CNT_W'(1);
                    pend_d  = '0;
                    if (BATCH == 1) begin
                        state_d       = HOLD;
                        out_valid_d   = 1'b1;
                        out_count_d   = FULL;
                        out_timeout_d = 1'b0;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end

            COLLECT: begin
                if (done_i) begin
                    count_d = CNT_W'(sat_add(32'(count), 32'd1, BATCH));
                    if (count_d == FULL) begin
                        state_d       = HOLD;
                        out_valid_d   = 1'b1;
                        out_count_d   = FULL;
                        out_timeout_d = 1'b0;
                    end
                end
`ifdef RUN_BATCHER_TIMEOUT_EN
                else if (gap_expired) begin
                    state_d       = HOLD;
                    out_valid_d   = 1'b1;
                    out_count_d   = count;
                    out_timeout_d = 1'b1;
                end
`endif
            end

            HOLD: begin
                out_valid_d = 1'b1;
                if (out_valid && out_ready) begin
                    pend_d = '0;
                    if (n == '0) begin
                        state_d       = IDLE;
                        out_valid_d   = 1'b0;
                        out_count_d   = '0;
                        out_timeout_d = 1'b0;
                    end else if (n == FULL) begin
                        // Next batch already complete: present it back-to-back.
                        count_d       = FULL;
                        out_count_d   = FULL;
                        out_timeout_d = 1'b0;
                    end else begin
                        state_d       = COLLECT;
                        count_d       = n;
                        out_valid_d   = 1'b0;
                        out_count_d   = '0;
                        out_timeout_d = 1'b0;
                    end
                end else if (done_i) begin
                    if (pend == FULL) begin
                        overrun_d = 1'b1;
                    end else begin
                        pend_d = pend + 1'b1;
                    end
                end
            end

            default: begin
                state_d       = IDLE;
                count_d       = '0;
                pend_d        = '0;
                out_valid_d   = 1'b0;
                out_count_d   = '0;
                out_timeout_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            pend        <= '0;
            out_valid   <= 1'b0;
            out_count   <= '0;
            out_timeout <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            count       <= count_d;
            pend        <= pend_d;
            out_valid   <= out_valid_d;
            out_count   <= out_count_d;
            out_timeout <= out_timeout_d;
            overrun     <= overrun_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_run_batcher.sv
// tb/tb_run_batcher.sv - self-checking bench for run_batcher with a batch-level reference model
module tb_run_batcher;

    localparam int B  = 4;
    localparam int T  = 16;
    localparam int CW = $clog2(B + 1);

`ifdef RUN_BATCHER_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          done_i;
    logic          out_ready;
    logic          out_valid;
    logic [CW-1:0] out_count;
    logic          out_timeout;
    logic          overrun;
    logic          busy;

    logic          done1;
    logic          ready1;
    logic          valid1;
    logic [0:0]    cnt1;
    logic          timeout1;
    logic          overrun1;
    logic          busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    run_batcher #(.BATCH(B), .TMO(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .done_i      (done_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .out_timeout (out_timeout),
        .overrun     (overrun),
        .busy        (busy)
    );

    run_batcher #(.BATCH(1), .TMO(T)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .done_i      (done1),
        .out_valid   (valid1),
        .out_ready   (ready1),
        .out_count   (cnt1),
        .out_timeout (timeout1),
        .overrun     (overrun1),
        .busy        (busy1)
    );

    // Reference model: runs accumulated but not yet presented (acc), the
    // presented batch (pv/pc/pto) and idle cycles since the last run.
    int m_acc, m_idle, m_pc;
    bit m_pv, m_pto, m_ovr;

    always @(posedge clk or negedge rst_n) begin : model
        int acc, idle, pc;
        bit pv, pto, ovr;
        if (!rst_n) begin
            m_acc <= 0; m_idle <= 0; m_pc <= 0;
            m_pv  <= 0; m_pto  <= 0; m_ovr <= 0;
        end else begin
            acc = m_acc; idle = m_idle; pc = m_pc;
            pv = m_pv; pto = m_pto; ovr = 0;
            if (pv && out_ready) begin
                pv   = 0;
                acc  = acc + int'(done_i);
                if (acc > B) acc = B;
                idle = 0;
                if (acc == B) begin pv = 1; pc = B; pto = 0; acc = 0; end
            end else if (pv) begin
                if (done_i) begin
                    if (acc == B) ovr = 1;
                    else acc = acc + 1;
                end
            end else if (done_i) begin
                acc  = acc + 1;
                idle = 0;
                if (acc == B) begin pv = 1; pc = B; pto = 0; acc = 0; end
            end else if (acc > 0 && TO_ON) begin
                idle = idle + 1;
                if (idle == T) begin pv = 1; pc = acc; pto = 1; acc = 0; end
            end
            m_acc <= acc; m_idle <= idle; m_pc <= pc;
            m_pv  <= pv;  m_pto  <= pto;  m_ovr <= ovr;
        end
    end

    task automatic step(input logic d, input logic r);
        done_i    = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 0; done_i = 0; out_ready = 0; done1 = 0; ready1 = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_count, out_timeout, overrun, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b expected=0", {out_valid, out_count, out_timeout, overrun, busy});
        end
        total++;
        if ({valid1, cnt1, timeout1, overrun1, busy1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs_b1 got=%b expected=0", {valid1, cnt1, timeout1, overrun1, busy1});
        end
        rst_n = 1;
        step(0, 0);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_full_batch;
        int early_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            step(1, 1);
            if (k < 4) begin
                if (out_valid) early_valid++;
                repeat (10) begin
                    step(0, 1);
                    if (out_valid) early_valid++;
                end
            end
        end
        total++;
        if (out_valid !== 1'b1 || out_count !== CW'(4) || out_timeout !== 1'b0) begin
            bad++;
            $display("FAIL full_batch got valid=%b count=%0d tmo=%b expected 1 4 0", out_valid, out_count, out_timeout);
        end
        total++;
        if (early_valid != 0) begin
            bad++;
            $display("FAIL full_batch_early got=%0d valid cycles expected 0", early_valid);
        end
        step(0, 1);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_batch_release valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_hold_overrun;
        int ovr_seen = 0;
        int lost     = 0;
        repeat (4) step(1, 0);
        for (int i = 0; i < 20; i++) begin
            step((i % 3 == 0) && (i < 18), 0);
            if (overrun === 1'b1) ovr_seen++;
            if (out_valid !== 1'b1 || out_count !== CW'(4)) lost++;
        end
        total++;
        if (ovr_seen != 2) begin
            bad++;
            $display("FAIL hold_overrun got=%0d pulses expected 2", ovr_seen);
        end
        total++;
        if (lost != 0) begin
            bad++;
            $display("FAIL hold_stable got=%0d unstable cycles expected 0", lost);
        end
        step(0, 1);
        total++;
        if (out_valid !== 1'b1 || out_count !== CW'(4) || out_timeout !== 1'b0) begin
            bad++;
            $display("FAIL second_batch got valid=%b count=%0d tmo=%b expected 1 4 0", out_valid, out_count, out_timeout);
        end
        step(0, 1);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL second_release valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_handshake_done;
        repeat (4) step(1, 0);
        repeat (2) step(1, 0);
        step(1, 1);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL hs_done_collect valid=%b busy=%b expected 0 1", out_valid, busy);
        end
        step(1, 0);
        total++;
        if (out_valid !== 1'b1 || out_count !== CW'(4)) begin
            bad++;
            $display("FAIL hs_done_complete valid=%b count=%0d expected 1 4", out_valid, out_count);
        end
        step(0, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hs_done_release valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_timeout;
        bit            rose = 0;
        int            at   = 0;
        logic [CW-1:0] cnt  = '0;
        logic          tmo  = 1'b0;
        step(1, 1);
        step(1, 1);
        for (int i = 1; i <= 40; i++) begin
            step(0, 0);
            if (out_valid === 1'b1 && !rose) begin
                rose = 1; at = i; cnt = out_count; tmo = out_timeout;
            end
        end
        if (TO_ON) begin
            total++;
            if (!rose || at != T || cnt !== CW'(2) || tmo !== 1'b1) begin
                bad++;
                $display("FAIL timeout_flush rose=%0d at=%0d count=%0d tmo=%b expected 1 %0d 2 1", rose, at, cnt, tmo, T);
            end
            step(0, 1);
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL timeout_release valid=%b busy=%b expected 0 0", out_valid, busy);
            end
        end else begin
            total++;
            if (rose || busy !== 1'b1) begin
                bad++;
                $display("FAIL no_timeout rose=%0d busy=%b expected 0 1", rose, busy);
            end
            step(1, 1);
            step(1, 1);
            total++;
            if (out_valid !== 1'b1 || out_count !== CW'(4) || out_timeout !== 1'b0) begin
                bad++;
                $display("FAIL no_timeout_fill valid=%b count=%0d tmo=%b expected 1 4 0", out_valid, out_count, out_timeout);
            end
            step(0, 1);
        end
    endtask

    task automatic test_reset_mid;
        repeat (7) step(1, 0);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_setup valid=%b expected 1", out_valid);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if ({out_valid, out_count, out_timeout, overrun, busy} !== '0) begin
            bad++;
            $display("FAIL reset_mid_async got=%b expected=0", {out_valid, out_count, out_timeout, overrun, busy});
        end
        @(posedge clk);
        #1 rst_n = 1;
        step(1, 1);
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_restart busy=%b valid=%b expected 1 0", busy, out_valid);
        end
        step(1, 1);
        step(1, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_count3 valid=%b expected 0", out_valid);
        end
        step(1, 1);
        total++;
        if (out_valid !== 1'b1 || out_count !== CW'(4)) begin
            bad++;
            $display("FAIL reset_mid_count4 valid=%b count=%0d expected 1 4", out_valid, out_count);
        end
        step(0, 1);
    endtask

    task automatic test_batch1;
        int held = 0;
        done_i = 0; out_ready = 1;
        done1 = 1; ready1 = 1;
        @(posedge clk); #1;
        total++;
        if (valid1 !== 1'b1 || cnt1 !== 1'b1) begin
            bad++;
            $display("FAIL b1_first valid=%b count=%0d expected 1 1", valid1, cnt1);
        end
        @(posedge clk); #1;
        total++;
        if (valid1 !== 1'b1 || cnt1 !== 1'b1) begin
            bad++;
            $display("FAIL b1_consecutive valid=%b count=%0d expected 1 1", valid1, cnt1);
        end
        done1 = 0;
        @(posedge clk); #1;
        total++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL b1_release valid=%b busy=%b expected 0 0", valid1, busy1);
        end
        done1 = 1; ready1 = 0;
        @(posedge clk); #1;
        done1 = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (valid1 === 1'b1) held++;
        end
        total++;
        if (held != 3) begin
            bad++;
            $display("FAIL b1_hold got=%0d held cycles expected 3", held);
        end
        ready1 = 1;
        @(posedge clk); #1;
        total++;
        if (valid1 !== 1'b0) begin
            bad++;
            $display("FAIL b1_accept valid=%b expected 0", valid1);
        end
    endtask

    task automatic test_random;
        int pd, pr;
        logic [CW+3:0] exp_v, got_v;
        for (int blk = 0; blk < 12; blk++) begin
            pd = (blk % 3 == 0) ? 8 : ((blk % 3 == 1) ? 50 : 90);
            pr = (blk % 4 == 0) ? 100 : ((blk % 4 == 1) ? 20 : 60);
            for (int c = 0; c < 50; c++) begin
                step($urandom_range(0, 99) < pd, $urandom_range(0, 99) < pr);
                exp_v = {m_pv, m_pv ? CW'(m_pc) : CW'(0), m_pv & m_pto, m_ovr, (m_pv || m_acc != 0)};
                got_v = {out_valid, out_valid ? out_count : CW'(0), out_valid & out_timeout, overrun, busy};
                total++;
                if (got_v !== exp_v) begin
                    bad++;
                    $display("FAIL random blk=%0d cyc=%0d got={v,cnt,tmo,ovr,busy}=%b expected=%b", blk, c, got_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_batch();
        test_hold_overrun();
        test_handshake_done();
        test_timeout();
        test_reset_mid();
        test_batch1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
